// File: rtl/m68k_bus_pkg.sv
// ---------------------------------------------------------------------------
// m68k_bus_pkg
// Shared types and constants for the 68000-style bus initiator.
//   bus_state_t  : sequencer states
//   BE_*         : byte-enable encodings {upper, lower}
//   mask_rdata() : zeroes the byte lanes that were not enabled on a read
// ---------------------------------------------------------------------------
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S1,
        S2,
        WAIT,
        SAMPLE,
        VSYNC,
        END,
        RECOVER
    } bus_state_t;

    localparam logic [1:0] BE_NONE  = 2'b00;
    localparam logic [1:0] BE_LOWER = 2'b01;
    localparam logic [1:0] BE_UPPER = 2'b10;
    localparam logic [1:0] BE_WORD  = 2'b11;

    function automatic logic [15:0] mask_rdata(input logic [15:0] d, input logic [1:0] be);
        logic [15:0] r;
        case (be)
            BE_WORD:  r = d;
            BE_UPPER: r = {d[15:8], 8'h00};
            BE_LOWER: r = {8'h00, d[7:0]};
            default:  r = 16'h0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/m68k_eclk_gen.sv
// ---------------------------------------------------------------------------
// m68k_eclk_gen
// Free-running 6800-style E clock. A counter runs 0..E_DIV-1; e_clk is high
// for the last 2*E_DIV/5 counts (6 low / 4 high for E_DIV=10).
//
// Ports:
//   i_clk     system clock
//   i_rst     synchronous reset, active high (counter=0, e_clk=0)
//   o_e_clk   E clock, registered
//   o_e_rise  high in the cycle before the edge on which e_clk rises
//   o_e_fall  high in the cycle before the edge on which e_clk falls
//             (i.e. the counter wraps to 0 on that edge)
// ---------------------------------------------------------------------------
module m68k_eclk_gen #(
    parameter int E_DIV = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_e_clk,
    output logic o_e_rise,
    output logic o_e_fall
);

    localparam int CNT_W    = $clog2(E_DIV);
    localparam int HIGH_CNT = 2 * E_DIV / 5;
    localparam int LOW_CNT  = E_DIV - HIGH_CNT;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(E_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(LOW_CNT);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(LOW_CNT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_e_clk;

    assign w_cnt_next = (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_e_clk <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            // derived from the next count so e_clk lines up with the counter
            r_e_clk <= (w_cnt_next >= CNT_HIGH);
        end
    end

    assign o_e_clk  = r_e_clk;
    assign o_e_rise = (r_cnt == CNT_PRE);
    assign o_e_fall = (r_cnt == CNT_MAX);

endmodule

// File: rtl/m68k_bus_initiator.sv
// ---------------------------------------------------------------------------
// m68k_bus_initiator
// Bus-master sequencer producing 68000-style asynchronous bus cycles from a
// valid/ready request port. Cycles end on DTACK, or on VPA with a 6800-style
// E-synchronous cycle (VMA).
//
// Optional feature (macro M68K_BUS_TIMEOUT_EN): bus-error timeout while
// waiting for DTACK/VPA. Without it WAIT holds until a responder answers.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we/addr/be/wdata  request fields; be==2'b00 returns an error
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             read data, held until next rsp_valid
//   rsp_err               bus error, qualifies rsp_valid
//   bus_a, bus_d_out, bus_d_oe, bus_d_in   address/data bus
//   as_n, uds_n, lds_n, rw                 bus strobes (active low), rw=1 read
//   dtack_n, vpa_n        asynchronous responder inputs
//   e_clk, vma_n          E clock and valid memory address
// ---------------------------------------------------------------------------
module m68k_bus_initiator
    import m68k_bus_pkg::*;
#(
    parameter int ADDR_W         = 23,
    parameter int E_DIV          = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_be,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bus_a,
    output logic [15:0]       bus_d_out,
    output logic              bus_d_oe,
    input  logic [15:0]       bus_d_in,
    output logic              as_n,
    output logic              uds_n,
    output logic              lds_n,
    output logic              rw,
    input  logic              dtack_n,
    input  logic              vpa_n,
    output logic              e_clk,
    output logic              vma_n
);

    bus_state_t        r_state;
    logic              r_we;
    logic [1:0]        r_be;
    logic              r_wr_strobe;   // second S2 cycle of a write
    logic              r_vma_active;  // VSYNC: VMA asserted, waiting for E fall
    logic              r_e_high_seen; // E has risen since VMA asserted
    logic              r_dtack_meta, r_dtack_sync;
    logic              r_vpa_meta, r_vpa_sync;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [15:0]       r_rsp_rdata;
    logic [ADDR_W-1:0] r_bus_a;
    logic [15:0]       r_bus_d_out;
    logic              r_bus_d_oe;
    logic              r_as_n, r_uds_n, r_lds_n, r_rw, r_vma_n;

    logic w_dtack, w_vpa;
    logic w_e_clk, w_e_rise, w_e_fall;

`ifdef M68K_BUS_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;
`endif

    assign w_dtack = ~r_dtack_sync;
    assign w_vpa   = ~r_vpa_sync;

    m68k_eclk_gen #(
        .E_DIV (E_DIV)
    ) u_eclk (
        .i_clk    (clk),
        .i_rst    (rst),
        .o_e_clk  (w_e_clk),
        .o_e_rise (w_e_rise),
        .o_e_fall (w_e_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_be          <= 2'b00;
            r_wr_strobe   <= 1'b0;
            r_vma_active  <= 1'b0;
            r_e_high_seen <= 1'b0;
            r_dtack_meta  <= 1'b1;
            r_dtack_sync  <= 1'b1;
            r_vpa_meta    <= 1'b1;
            r_vpa_sync    <= 1'b1;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_rdata   <= 16'h0000;
            r_bus_a       <= '0;
            r_bus_d_out   <= 16'h0000;
            r_bus_d_oe    <= 1'b0;
            r_as_n        <= 1'b1;
            r_uds_n       <= 1'b1;
            r_lds_n       <= 1'b1;
            r_rw          <= 1'b1;
            r_vma_n       <= 1'b1;
`ifdef M68K_BUS_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
            r_dtack_meta <= dtack_n;
            r_dtack_sync <= r_dtack_meta;
            r_vpa_meta   <= vpa_n;
            r_vpa_sync   <= r_vpa_meta;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_req_ready && req_valid) begin
                        r_req_ready <= 1'b0;
                        r_we        <= req_we;
                        r_be        <= req_be;
`ifdef M68K_BUS_TIMEOUT_EN
                        r_timeout   <= 1'b0;
`endif
                        if (req_be == BE_NONE) begin
                            // rejected without touching the bus
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_state     <= RECOVER;
                        end else begin
                            r_bus_a <= req_addr;
                            r_rw    <= ~req_we;
                            if (req_we) begin
                                r_bus_d_out <= req_wdata;
                            end
                            r_state <= S1;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end

                S1: begin
                    r_as_n      <= 1'b0;
                    r_wr_strobe <= 1'b0;
                    if (!r_we) begin
                        r_uds_n <= ~r_be[1];
                        r_lds_n <= ~r_be[0];
                    end
                    r_state <= S2;
                end

                S2: begin
                    if (r_we && !r_wr_strobe) begin
                        // data is on the bus one cycle before the strobes fall
                        r_bus_d_oe  <= 1'b1;
                        r_wr_strobe <= 1'b1;
                    end else begin
                        if (r_we) begin
                            r_uds_n <= ~r_be[1];
                            r_lds_n <= ~r_be[0];
                        end
`ifdef M68K_BUS_TIMEOUT_EN
                        r_to_cnt <= TO_LOAD;
`endif
                        r_state <= WAIT;
                    end
                end

                WAIT: begin
                    if (w_dtack) begin
                        r_state <= SAMPLE;
                    end else if (w_vpa) begin
                        r_vma_active  <= 1'b0;
                        r_e_high_seen <= 1'b0;
                        r_state       <= VSYNC;
                    end
`ifdef M68K_BUS_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_timeout   <= 1'b1;
                        r_rsp_rdata <= 16'h0000;
                        r_state     <= END;
                    end else begin
                        r_to_cnt <= r_to_cnt - 1'b1;
                    end
`endif
                end

                SAMPLE: begin
                    if (!r_we) begin
                        r_rsp_rdata <= mask_rdata(bus_d_in, r_be);
                    end
                    r_state <= END;
                end

                VSYNC: begin
                    if (!r_vma_active) begin
                        // VMA falls on the edge where the E counter wraps to 0
                        if (w_e_fall) begin
                            r_vma_n      <= 1'b0;
                            r_vma_active <= 1'b1;
                        end
                    end else begin
                        if (w_e_rise) begin
                            r_e_high_seen <= 1'b1;
                        end
                        if (w_e_fall && r_e_high_seen) begin
                            if (!r_we) begin
                                r_rsp_rdata <= mask_rdata(bus_d_in, r_be);
                            end
                            r_vma_n <= 1'b1;
                            r_state <= END;
                        end
                    end
                end

                END: begin
                    r_as_n      <= 1'b1;
                    r_uds_n     <= 1'b1;
                    r_lds_n     <= 1'b1;
                    r_vma_n     <= 1'b1;
                    r_rw        <= 1'b1;
                    r_bus_d_oe  <= 1'b0;
                    r_rsp_valid <= 1'b1;
`ifdef M68K_BUS_TIMEOUT_EN
                    r_rsp_err   <= r_timeout;
`endif
                    r_state     <= RECOVER;
                end

                RECOVER: begin
                    if (r_dtack_sync && r_vpa_sync) begin
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign bus_a     = r_bus_a;
    assign bus_d_out = r_bus_d_out;
    assign bus_d_oe  = r_bus_d_oe;
    assign as_n      = r_as_n;
    assign uds_n     = r_uds_n;
    assign lds_n     = r_lds_n;
    assign rw        = r_rw;
    assign vma_n     = r_vma_n;
    assign e_clk     = w_e_clk;

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_m68k_bus_initiator
// Directed bench for m68k_bus_initiator with a small responder model whose
// DTACK delay and DTACK/VPA choice are set per transaction. Latencies are
// counted in clock edges after the accepting edge (m); a zero-wait read
// completes at m=6, i.e. seven clocks counting the acceptance cycle.
// ---------------------------------------------------------------------------
module tb_m68k_bus_initiator;

    localparam int ADDR_W         = 23;
    localparam int E_DIV          = 10;
    localparam int TIMEOUT_CYCLES = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [1:0]        req_be = 2'b00;
    logic [15:0]       req_wdata = 16'h0000;
    logic              rsp_valid;
    logic [15:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] bus_a;
    logic [15:0]       bus_d_out;
    logic              bus_d_oe;
    logic [15:0]       bus_d_in = 16'h0000;
    logic              as_n, uds_n, lds_n, rw;
    logic              dtack_n, vpa_n;
    logic              e_clk, vma_n;

    // responder: 0 none, 1 dtack, 2 vpa, 3 both
    int resp_mode = 0;
    int resp_dly  = 0;
    int as_cnt    = 0;
    int e_model   = 0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) as_cnt <= as_n ? 0 : as_cnt + 1;
    always @(posedge clk) e_model <= rst ? 0 : ((e_model == E_DIV - 1) ? 0 : e_model + 1);

    assign dtack_n = !(((resp_mode == 1) || (resp_mode == 3)) && !as_n && (as_cnt >= resp_dly));
    assign vpa_n   = !(((resp_mode == 2) || (resp_mode == 3)) && !as_n);

    m68k_bus_initiator #(
        .ADDR_W         (ADDR_W),
        .E_DIV          (E_DIV),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_a     (bus_a),
        .bus_d_out (bus_d_out),
        .bus_d_oe  (bus_d_oe),
        .bus_d_in  (bus_d_in),
        .as_n      (as_n),
        .uds_n     (uds_n),
        .lds_n     (lds_n),
        .rw        (rw),
        .dtack_n   (dtack_n),
        .vpa_n     (vpa_n),
        .e_clk     (e_clk),
        .vma_n     (vma_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // per-transaction observations
    int          o_lat, o_as_low, o_uds_low, o_lds_low, o_split, o_rw_low;
    int          o_doe_first, o_lds_fall, o_vma_low, o_vma_fall_e, o_vma_rise_e;
    int          o_ready_hi, o_eclk_bad;
    logic        o_vma_prev, o_as_seen, o_rw_at_as, o_err;
    logic [15:0] o_dout_at_strobe, o_rdata;
    logic [ADDR_W-1:0] o_a_at_as;

    task automatic clear_obs();
        o_lat = -1; o_as_low = 0; o_uds_low = 0; o_lds_low = 0; o_split = 0;
        o_rw_low = 0; o_doe_first = -1; o_lds_fall = -1; o_vma_low = 0;
        o_vma_fall_e = -1; o_vma_rise_e = -1; o_ready_hi = 0; o_eclk_bad = 0;
        o_vma_prev = 1'b0; o_as_seen = 1'b0; o_rw_at_as = 1'b1;
        o_dout_at_strobe = 16'h0000; o_a_at_as = '0;
    endtask

    task automatic observe(input int m);
        if (!as_n) begin
            o_as_low++;
            if (!o_as_seen) begin
                o_as_seen  = 1'b1;
                o_a_at_as  = bus_a;
                o_rw_at_as = rw;
            end
        end
        if (!uds_n) o_uds_low++;
        if (!lds_n) o_lds_low++;
        if (uds_n != lds_n) o_split++;
        if (!rw) o_rw_low++;
        if (bus_d_oe && o_doe_first < 0) o_doe_first = m;
        if (!lds_n && o_lds_fall < 0) begin
            o_lds_fall = m;
            o_dout_at_strobe = bus_d_out;
        end
        if (!vma_n) begin
            if (!o_vma_prev) o_vma_fall_e = e_model;
            o_vma_low++;
        end else if (o_vma_prev) begin
            o_vma_rise_e = e_model;
        end
        o_vma_prev = !vma_n;
        if (req_ready) o_ready_hi++;
        if (e_clk !== (e_model >= E_DIV - 2 * E_DIV / 5)) o_eclk_bad++;
    endtask

    task automatic start_req(input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [1:0] be, input logic [15:0] wdata);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_wait", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [1:0] be, input logic [15:0] wdata, input int budget);
        int m;
        start_req(we, addr, be, wdata);
        clear_obs();
        m = 0;
        observe(0);
        while (!rsp_valid && m < budget) begin
            @(posedge clk);
            #1;
            m++;
            observe(m);
        end
        o_lat   = rsp_valid ? m : -1;
        o_rdata = rsp_rdata;
        o_err   = rsp_err;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int rsp_seen, ready_hi, as_low;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_as_n",   {31'd0, as_n},  32'd1);
        check_eq("rst_uds_n",  {31'd0, uds_n}, 32'd1);
        check_eq("rst_lds_n",  {31'd0, lds_n}, 32'd1);
        check_eq("rst_vma_n",  {31'd0, vma_n}, 32'd1);
        check_eq("rst_rw",     {31'd0, rw},    32'd1);
        check_eq("rst_d_oe",   {31'd0, bus_d_oe}, 32'd0);
        check_eq("rst_bus_a",  32'(bus_a), 32'd0);
        check_eq("rst_d_out",  32'(bus_d_out), 32'd0);
        check_eq("rst_ready",  {31'd0, req_ready}, 32'd0);
        check_eq("rst_rsp",    {30'd0, rsp_valid, rsp_err}, 32'd0);
        check_eq("rst_rdata",  32'(rsp_rdata), 32'd0);
        check_eq("rst_e_clk",  {31'd0, e_clk}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // ---- word read, DTACK two cycles late ----
        resp_mode = 1; resp_dly = 2; bus_d_in = 16'hBEEF;
        run_txn(1'b0, 23'h200000, 2'b11, 16'h0000, 60);
        check_eq("rd_lat",      32'(o_lat), 32'd8);
        check_eq("rd_rdata",    32'(o_rdata), 32'hBEEF);
        check_eq("rd_err",      {31'd0, o_err}, 32'd0);
        check_eq("rd_addr",     32'(o_a_at_as), 32'h200000);
        check_eq("rd_uds_low",  32'(o_uds_low), 32'd7);
        check_eq("rd_split",    32'(o_split), 32'd0);
        check_eq("rd_rw_low",   32'(o_rw_low), 32'd0);
        check_eq("rd_ready_hi", 32'(o_ready_hi), 32'd0);

        // ---- lower-byte write, immediate DTACK ----
        resp_mode = 1; resp_dly = 0;
        run_txn(1'b1, 23'h200001, 2'b01, 16'h00A5, 60);
        check_eq("wr_lat",       32'(o_lat), 32'd6);
        check_eq("wr_addr",      32'(o_a_at_as), 32'h200001);
        check_eq("wr_rw_at_as",  {31'd0, o_rw_at_as}, 32'd0);
        check_eq("wr_uds_low",   32'(o_uds_low), 32'd0);
        check_eq("wr_lds_low",   32'(o_lds_low), 32'd3);
        check_eq("wr_doe_first", 32'(o_doe_first), 32'd2);
        check_eq("wr_lds_fall",  32'(o_lds_fall), 32'd3);
        check_eq("wr_d_out",     32'(o_dout_at_strobe), 32'h00A5);
        check_eq("wr_err",       {31'd0, o_err}, 32'd0);

        // ---- zero-wait word read ----
        resp_mode = 1; resp_dly = 0; bus_d_in = 16'h1357;
        run_txn(1'b0, 23'h000010, 2'b11, 16'h0000, 60);
        check_eq("zw_lat",   32'(o_lat), 32'd6);
        check_eq("zw_rdata", 32'(o_rdata), 32'h1357);

        // ---- upper-byte read, one wait state ----
        resp_mode = 1; resp_dly = 1; bus_d_in = 16'hCAFE;
        run_txn(1'b0, 23'h000020, 2'b10, 16'h0000, 60);
        check_eq("ub_lat",    32'(o_lat), 32'd7);
        check_eq("ub_rdata",  32'(o_rdata), 32'hCA00);
        check_eq("ub_lds_low", 32'(o_lds_low), 32'd0);

        // ---- VPA read, lower byte ----
        resp_mode = 2; resp_dly = 0; bus_d_in = 16'h5A3C;
        run_txn(1'b0, 23'h7F0000, 2'b01, 16'h0000, 80);
        check_eq("vpa_lat_ok",  {31'd0, (o_lat >= 0) && (o_lat <= 2 * E_DIV + 8)}, 32'd1);
        check_eq("vpa_rdata",   32'(o_rdata), 32'h003C);
        check_eq("vpa_err",     {31'd0, o_err}, 32'd0);
        check_eq("vpa_fall_e",  32'(o_vma_fall_e), 32'd0);
        check_eq("vpa_rise_e",  32'(o_vma_rise_e), 32'd0);
        check_eq("vpa_low_len", 32'(o_vma_low), 32'(E_DIV));
        check_eq("eclk_shape",  32'(o_eclk_bad), 32'd0);

        // ---- DTACK and VPA together: DTACK wins ----
        resp_mode = 3; resp_dly = 0; bus_d_in = 16'h0F0F;
        run_txn(1'b0, 23'h000030, 2'b11, 16'h0000, 60);
        check_eq("both_lat",   32'(o_lat), 32'd6);
        check_eq("both_vma",   32'(o_vma_low), 32'd0);
        check_eq("both_rdata", 32'(o_rdata), 32'h0F0F);

        // ---- be == 00 rejected ----
        resp_mode = 1; resp_dly = 0;
        run_txn(1'b0, 23'h000040, 2'b00, 16'h0000, 20);
        check_eq("be0_lat",    32'(o_lat), 32'd0);
        check_eq("be0_err",    {31'd0, o_err}, 32'd1);
        check_eq("be0_as_low", 32'(o_as_low), 32'd0);

        // ---- reset while waiting for a responder ----
        resp_mode = 0;
        rsp_seen = 0;
        start_req(1'b0, 23'h000100, 2'b11, 16'h0000);
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rsp_valid) rsp_seen++;
        end
        check_eq("wait_as_low", {31'd0, as_n}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rstw_strobes", {29'd0, as_n, uds_n, lds_n}, 32'd7);
        check_eq("rstw_ready",   {31'd0, req_ready}, 32'd0);
        ready_hi = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (req_ready) ready_hi++;
            if (rsp_valid) rsp_seen++;
        end
        check_eq("rstw_ready_held", 32'(ready_hi), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        if (rsp_valid) rsp_seen++;
        check_eq("rstw_ready_rel", {31'd0, req_ready}, 32'd1);
        check_eq("rstw_no_rsp",    32'(rsp_seen), 32'd0);

        // ---- no responder at all ----
        resp_mode = 0;
`ifdef M68K_BUS_TIMEOUT_EN
        run_txn(1'b0, 23'h000200, 2'b11, 16'h0000, 200);
        check_eq("to_lat",   32'(o_lat), 32'(TIMEOUT_CYCLES + 3));
        check_eq("to_err",   {31'd0, o_err}, 32'd1);
        check_eq("to_rdata", 32'(o_rdata), 32'd0);
`else
        start_req(1'b0, 23'h000200, 2'b11, 16'h0000);
        as_low = 0;
        rsp_seen = 0;
        repeat (500) begin
            @(posedge clk);
            #1;
            if (!as_n) as_low++;
            if (rsp_valid) rsp_seen++;
        end
        check_eq("hang_as_low", 32'(as_low), 32'd500);
        check_eq("hang_no_rsp", 32'(rsp_seen), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
